// File: rtl/weight_pattern_gen_pkg.sv
// rtl/weight_pattern_gen_pkg.sv - shared types and helpers for the weight pattern generator
// Purpose: FSM state type plus popcount/binomial helpers used by assertions and the bench.
// Ports: none (package).
package wpg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int MAX_N = 16;

  function automatic int popcount(input logic [MAX_N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Number of K-subsets of N; incremental form keeps every quotient exact.
  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    if (k < 0 || k > n) return 0;
    for (int i = 0; i < k; i++) begin
      c = c * (n - i) / (i + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/weight_pattern_gen_if.sv
// rtl/weight_pattern_gen_if.sv - request/pattern handshake bundle
// Purpose: groups the count request channel, the pattern output channel and err.
// Ports (signals): in_valid/in_ready/in_count request side; out_valid/out_ready/
//   out_pattern/out_last/out_index pattern side; err rejected-request pulse.
// Modports: master drives requests and consumes patterns; slave is the generator.
interface weight_pattern_gen_if #(
  parameter int N = 3
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = N;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_pattern;
  logic          out_last;
  logic [IW-1:0] out_index;
  logic          err;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_pattern, out_last, out_index, err
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_pattern, out_last, out_index, err
  );

endinterface

// File: rtl/weight_pattern_gen_next.sv
// rtl/weight_pattern_gen_next.sv - next larger value with the same popcount
// Purpose: combinational Gosper step without division.
// Ports: pattern_i current N-bit vector; next_o next same-weight vector;
//   last_o high when pattern_i is the largest vector of its weight (or zero).
module next_weight_pattern #(
  parameter int N = 3
) (
  input  logic [N-1:0] pattern_i,
  output logic [N-1:0] next_o,
  output logic         last_o
);

  // One extra bit so the carry out of the top bit is visible.
  logic [N:0] x_ext;
  logic [N:0] low_bit;
  logic [N:0] sum;
  logic [N:0] diff;
  logic [N:0] next_ext;
  logic [5:0] tz;

  assign x_ext   = {1'b0, pattern_i};
  assign low_bit = x_ext & (~x_ext + (N+1)'(1));
  assign sum     = x_ext + low_bit;
  assign diff    = sum ^ x_ext;

  // Trailing-zero count: the lowest set bit wins.
  always_comb begin
    tz = 6'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pattern_i[i]) tz = 6'(i);
    end
  end

  // The shift replaces the divide by low_bit; shifted-in ones refill the bottom.
  assign next_ext = sum | (diff >> (tz + 6'd2));
  assign next_o   = next_ext[N-1:0];

  // The carry reaches bit N only when the ones block already touches the top.
  // The shifted term never reaches bit N, so next_ext[N] equals that carry.
  assign last_o = next_ext[N] | (pattern_i == '0);

endmodule

// File: rtl/weight_pattern_gen.sv
// rtl/weight_pattern_gen.sv - enumerates all N-bit vectors of popcount K in ascending order
// Purpose: accepts a count K, then emits C(N,K) patterns one per handshake, tagging the last.
// Ports: clk rising-edge clock; rst async active-high reset;
//   bus (slave) request channel, pattern channel and err pulse.
module weight_pattern_gen
  import wpg_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_pattern_gen_if.slave  bus
);

  localparam int IW = N;

  state_t        state_q, state_d;
  logic [N-1:0]  pattern_q, pattern_d;
  logic [IW-1:0] index_q, index_d;
  logic          err_q, err_d;

  logic [N-1:0]  nxt_pattern;
  logic          cur_last;
  logic          k_ok;
  logic [N:0]    start_ext;

  next_weight_pattern #(.N(N)) u_next (
    .pattern_i (pattern_q),
    .next_o    (nxt_pattern),
    .last_o    (cur_last)
  );

  assign k_ok      = (int'(bus.in_count) <= N);
  // Low K bits set; computed one bit wider so K == N does not overflow.
  assign start_ext = ((N+1)'(1) << bus.in_count) - (N+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      index_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      index_q   <= index_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    index_d   = index_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (k_ok) begin
            state_d   = EMIT;
            pattern_d = start_ext[N-1:0];
            index_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (cur_last) begin
            state_d   = IDLE;
            pattern_d = '0;
            index_d   = '0;
          end else begin
            pattern_d = nxt_pattern;
            index_d   = index_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == EMIT);
  assign bus.out_pattern = pattern_q;
  assign bus.out_last    = (state_q == EMIT) && cur_last;
  assign bus.out_index   = index_q;
  assign bus.err         = err_q;

  a_err_excl: assert property (@(posedge clk) disable iff (rst) !(bus.err && bus.out_valid));

endmodule

// File: tb/tb_weight_pattern_gen.sv
// tb/tb_weight_pattern_gen.sv - self-checking bench for weight_pattern_gen at N=3,4,5
module tb_weight_pattern_gen;
  import wpg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         sel = 0;
  logic       req_valid = 1'b0;
  logic [3:0] req_count = '0;
  logic       rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weight_pattern_gen_if #(.N(3)) if3 ();
  weight_pattern_gen_if #(.N(4)) if4 ();
  weight_pattern_gen_if #(.N(5)) if5 ();

  assign if3.in_valid  = req_valid && (sel == 0);
  assign if4.in_valid  = req_valid && (sel == 1);
  assign if5.in_valid  = req_valid && (sel == 2);
  assign if3.in_count  = req_count[1:0];
  assign if4.in_count  = req_count[2:0];
  assign if5.in_count  = req_count[2:0];
  assign if3.out_ready = rdy;
  assign if4.out_ready = rdy;
  assign if5.out_ready = rdy;

  weight_pattern_gen #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  weight_pattern_gen #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  weight_pattern_gen #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  logic        obs_valid, obs_last, obs_err, obs_in_ready;
  logic [15:0] obs_pattern, obs_index;

  always_comb begin
    obs_valid = 1'b0; obs_last = 1'b0; obs_err = 1'b0; obs_in_ready = 1'b0;
    obs_pattern = '0; obs_index = '0;
    case (sel)
      0: begin
        obs_valid = if3.out_valid; obs_last = if3.out_last; obs_err = if3.err;
        obs_in_ready = if3.in_ready; obs_pattern = 16'(if3.out_pattern); obs_index = 16'(if3.out_index);
      end
      1: begin
        obs_valid = if4.out_valid; obs_last = if4.out_last; obs_err = if4.err;
        obs_in_ready = if4.in_ready; obs_pattern = 16'(if4.out_pattern); obs_index = 16'(if4.out_index);
      end
      default: begin
        obs_valid = if5.out_valid; obs_last = if5.out_last; obs_err = if5.err;
        obs_in_ready = if5.in_ready; obs_pattern = 16'(if5.out_pattern); obs_index = 16'(if5.out_index);
      end
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called and returns on a falling edge so consecutive calls are back-to-back.
  task automatic run_seq(input int s, input int k, input int mode, input int exp_len, input string tag);
    int n, got, cyc, ph, prev_pat;
    bit prev_hold, err_seen;
    int exp_q[$];
    n = 3 + s;
    sel = s;
    // Reference: brute-force enumeration of every n-bit value with k ones.
    for (int v = 0; v < (1 << n); v++) begin
      if ($countones(v) == k) exp_q.push_back(v);
    end
    check({tag, "_in_ready_idle"}, int'(obs_in_ready), 1);
    req_count = 4'(k);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 0; cyc = 0; ph = 0; prev_pat = 0; prev_hold = 1'b0; err_seen = 1'b0;
    while (cyc < 200) begin
      if (obs_err) err_seen = 1'b1;
      if (!obs_valid) break;
      if (prev_hold) check({tag, "_stable"}, int'(obs_pattern), prev_pat);
      if (got < exp_q.size()) begin
        check({tag, "_pattern"}, int'(obs_pattern), exp_q[got]);
        check({tag, "_index"}, int'(obs_index), got);
        check({tag, "_last"}, int'(obs_last), int'(got == exp_q.size() - 1));
      end
      check({tag, "_popcount"}, popcount(obs_pattern), k);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((ph % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      if (rdy) begin
        got++;
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        prev_pat = int'(obs_pattern);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    rdy = 1'b0;
    check({tag, "_handshakes"}, got, exp_len);
    check({tag, "_return_in_ready"}, int'(obs_in_ready), 1);
    check({tag, "_return_valid"}, int'(obs_valid), 0);
    check({tag, "_no_err"}, int'(err_seen), 0);
  endtask

  task automatic run_err(input int s, input int k, input string tag);
    sel = s;
    check({tag, "_in_ready_before"}, int'(obs_in_ready), 1);
    req_count = 4'(k);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_err_pulse"}, int'(obs_err), 1);
    check({tag, "_valid_low"}, int'(obs_valid), 0);
    check({tag, "_in_ready_after"}, int'(obs_in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_err_cleared"}, int'(obs_err), 0);
    check({tag, "_valid_still_low"}, int'(obs_valid), 0);
  endtask

  typedef struct {
    int    s;
    int    k;
    int    mode;
    int    exp_len;
    string tag;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 2, 0, 3,  "n3k2"};
    vecs[1] = '{0, 0, 0, 1,  "n3k0"};
    vecs[2] = '{0, 3, 0, 1,  "n3k3"};
    vecs[3] = '{1, 2, 1, 6,  "n4k2_toggle"};
    vecs[4] = '{2, 0, 0, 1,  "n5k0"};
    vecs[5] = '{2, 1, 2, 5,  "n5k1"};
    vecs[6] = '{2, 2, 0, 10, "n5k2"};
    vecs[7] = '{2, 3, 1, 10, "n5k3"};
    vecs[8] = '{2, 4, 2, 5,  "n5k4"};
    vecs[9] = '{2, 5, 0, 1,  "n5k5"};

    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(obs_in_ready), 1);
    check("rst_valid", int'(obs_valid), 0);
    check("rst_pattern", int'(obs_pattern), 0);
    check("rst_last", int'(obs_last), 0);
    check("rst_index", int'(obs_index), 0);
    check("rst_err", int'(obs_err), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_seq(vecs[i].s, vecs[i].k, vecs[i].mode, vecs[i].exp_len, vecs[i].tag);
    end

    // Reset in the middle of an N=4, K=2 stream after 0101 is accepted.
    sel = 1;
    req_count = 4'd2;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_p0", int'(obs_pattern), 3);
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_p1", int'(obs_pattern), 5);
    @(posedge clk);
    @(negedge clk);
    check("mid_p2", int'(obs_pattern), 6);
    rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(obs_valid), 0);
    check("mid_rst_in_ready", int'(obs_in_ready), 1);
    check("mid_rst_pattern", int'(obs_pattern), 0);
    check("mid_rst_index", int'(obs_index), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seq(1, 1, 0, 4, "n4k1_after_rst");

    // Counts above N that the count field can still carry.
    run_err(1, 5, "n4k5");
    run_err(1, 7, "n4k7");
    run_err(2, 6, "n5k6");

    for (int r = 0; r < 24; r++) begin
      int s, n, k, kmax;
      s = $urandom_range(0, 2);
      n = 3 + s;
      kmax = (s == 0) ? 3 : 7;
      k = $urandom_range(0, kmax);
      if (k > n) run_err(s, k, "rnd_err");
      else run_seq(s, k, 2, binom(n, k), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
